// File: rtl/seq_pkg.sv
// Shared encodings for the memory-cycle sequencer: state codes, select codes and the control word.
package seq_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned CNT_W   = 8;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_IDLE    = 4'd0;
  localparam state_t S_F_ADDR  = 4'd1;
  localparam state_t S_F_MEM   = 4'd2;
  localparam state_t S_F_LATCH = 4'd3;
  localparam state_t S_DECODE  = 4'd4;
  localparam state_t S_EXEC    = 4'd5;
  localparam state_t S_ST_DATA = 4'd6;
  localparam state_t S_LS_ADDR = 4'd7;
  localparam state_t S_D_MEM   = 4'd8;
  localparam state_t S_L_LATCH = 4'd9;
  localparam state_t S_L_WB    = 4'd10;
  localparam state_t S_PC_UPD  = 4'd11;
  localparam state_t S_ERR     = 4'd12;

  localparam logic [1:0] MARSEL_ALU  = 2'd0;
  localparam logic [1:0] MARSEL_PC   = 2'd1;
  localparam logic [1:0] MDRSEL_RAM  = 2'd0;
  localparam logic [1:0] MDRSEL_RFA  = 2'd1;
  localparam logic [1:0] ALUSEL_RFB  = 2'd0;
  localparam logic [1:0] ALUSEL_SIMM = 2'd1;
  localparam logic [1:0] RCSEL_RD    = 2'd0;
  localparam logic [1:0] CINSEL_MDR  = 2'd3;
  localparam logic [1:0] NPCSEL_ADD  = 2'd0;
  localparam logic [1:0] OP_FMT_MEM  = 2'b11;

  // Datapath control word; enables are active low
  typedef struct packed {
    logic            mfa;
    logic            mop_sel;
    logic            aop_sel;
    logic [OP_W-1:0] op1;
    logic [1:0]      mar_sel;
    logic [1:0]      mdr_sel;
    logic [1:0]      alu_sel;
    logic            ra_sel;
    logic [1:0]      rc_sel;
    logic [1:0]      cin_sel;
    logic [1:0]      npc_sel;
    logic            mare;
    logic            mdre;
    logic            ire;
    logic            rfe;
    logic            pce;
    logic            npce;
    logic            exec_req;
    logic            busy;
  } ctrl_t;

  // Everything inactive: enables high, selects and opcode zero, no request
  function automatic ctrl_t ctrl_quiet();
    ctrl_t c;
    c      = '0;
    c.mare = 1'b1;
    c.mdre = 1'b1;
    c.ire  = 1'b1;
    c.rfe  = 1'b1;
    c.pce  = 1'b1;
    c.npce = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/seq_ctrl_decode.sv
// Combinational state -> datapath control word decoder.
module seq_ctrl_decode
  import seq_pkg::*;
#(
  parameter logic [OP_W-1:0] FETCH_OP = 6'h08,
  parameter logic [OP_W-1:0] ADD_OP   = 6'h00
) (
  input  state_t state,
  input  logic   simm,
  output ctrl_t  ctrl_c
);

  always_comb begin
    ctrl_c      = ctrl_quiet();
    ctrl_c.busy = (state != S_IDLE);
    case (state)
      S_F_ADDR: begin
        ctrl_c.mar_sel = MARSEL_PC;
        ctrl_c.mare    = 1'b0;
      end
      S_F_MEM: begin
        ctrl_c.mop_sel = 1'b1;
        ctrl_c.op1     = FETCH_OP;
        ctrl_c.mfa     = 1'b1;
      end
      S_F_LATCH: begin
        ctrl_c.mdr_sel = MDRSEL_RAM;
        ctrl_c.mdre    = 1'b0;
        ctrl_c.ire     = 1'b0;
      end
      S_EXEC: ctrl_c.exec_req = 1'b1;
      // rd goes into MDR here, one state before RA switches back to rs1
      S_ST_DATA: begin
        ctrl_c.ra_sel  = 1'b1;
        ctrl_c.mdr_sel = MDRSEL_RFA;
        ctrl_c.mdre    = 1'b0;
      end
      S_LS_ADDR: begin
        ctrl_c.ra_sel  = 1'b0;
        ctrl_c.aop_sel = 1'b1;
        ctrl_c.op1     = ADD_OP;
        ctrl_c.alu_sel = simm ? ALUSEL_SIMM : ALUSEL_RFB;
        ctrl_c.mar_sel = MARSEL_ALU;
        ctrl_c.mare    = 1'b0;
      end
      S_D_MEM: begin
        ctrl_c.mop_sel = 1'b0;
        ctrl_c.mfa     = 1'b1;
      end
      S_L_LATCH: begin
        ctrl_c.mdr_sel = MDRSEL_RAM;
        ctrl_c.mdre    = 1'b0;
      end
      S_L_WB: begin
        ctrl_c.rc_sel  = RCSEL_RD;
        ctrl_c.cin_sel = CINSEL_MDR;
        ctrl_c.rfe     = 1'b0;
      end
      S_PC_UPD: begin
        ctrl_c.npc_sel = NPCSEL_ADD;
        ctrl_c.pce     = 1'b0;
        ctrl_c.npce    = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_cycle_sequencer.sv
// Fetch/decode/load-store control sequencer with RAM MFA/MFC handshake and ExecReq/ExecAck hand-off.
// Optional MEM_TIMEOUT_EN adds a stalled-access watchdog that parks the sequencer in ERR.
module mem_cycle_sequencer
  import seq_pkg::*;
#(
  parameter logic [OP_W-1:0] FETCH_OP = 6'h08,
  parameter logic [OP_W-1:0] ADD_OP   = 6'h00
`ifdef MEM_TIMEOUT_EN
  , parameter int unsigned   TIMEOUT_CYCLES = 64
`endif
) (
  input  logic            Clk,
  input  logic            Clr,
  input  logic            Start,
  input  logic [31:0]     IR,
  input  logic            MFC,
  input  logic            ExecAck,
  output logic            MFA,
  output logic            MOP_SEL,
  output logic            AOP_SEL,
  output logic [OP_W-1:0] OP1,
  output logic [1:0]      MAR_SEL,
  output logic [1:0]      MDR_SEL,
  output logic [1:0]      ALU_SEL,
  output logic            RA_SEL,
  output logic [1:0]      RC_SEL,
  output logic [1:0]      CIN_SEL,
  output logic [1:0]      nPC_SEL,
  output logic            MARE,
  output logic            MDRE,
  output logic            IRE,
  output logic            RFE,
  output logic            PCE,
  output logic            nPCE,
  output logic            ExecReq,
  output logic            Busy,
  output logic            MemErr
);

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_c;
  logic   is_mem, is_store, timeout_c;
  logic   unused_ir;

  assign is_mem    = (IR[31:30] == OP_FMT_MEM);
  assign is_store  = IR[21];
  assign unused_ir = ^{IR[29:22], IR[20:14], IR[12:0]};

`ifdef MEM_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_err_q;
  logic             in_mem;

  assign in_mem    = (state_q == S_F_MEM) || (state_q == S_D_MEM);
  assign timeout_c = in_mem && !MFC && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counts stalled MFA cycles; zero whenever no access is in flight
  always_comb begin
    cnt_d = '0;
    if (in_mem && !MFC) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (timeout_c) mem_err_q <= 1'b1;
    end
  end

  assign MemErr = mem_err_q;
`else
  assign timeout_c = 1'b0;
  assign MemErr    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (Start) state_d = S_F_ADDR;
      S_F_ADDR:  state_d = S_F_MEM;
      S_F_MEM: begin
        if (MFC)            state_d = S_F_LATCH;
        else if (timeout_c) state_d = S_ERR;
      end
      S_F_LATCH: state_d = S_DECODE;
      S_DECODE: begin
        if (!is_mem)       state_d = S_EXEC;
        else if (is_store) state_d = S_ST_DATA;
        else               state_d = S_LS_ADDR;
      end
      S_EXEC:    if (ExecAck) state_d = S_PC_UPD;
      S_ST_DATA: state_d = S_LS_ADDR;
      S_LS_ADDR: state_d = S_D_MEM;
      S_D_MEM: begin
        if (MFC)            state_d = is_store ? S_PC_UPD : S_L_LATCH;
        else if (timeout_c) state_d = S_ERR;
      end
      S_L_LATCH: state_d = S_L_WB;
      S_L_WB:    state_d = S_PC_UPD;
      S_PC_UPD:  state_d = Start ? S_F_ADDR : S_IDLE;
      S_ERR:     state_d = S_ERR;
      default:   state_d = S_IDLE;
    endcase
  end

  // Control word is decoded from the next state so it registers alongside it
  seq_ctrl_decode #(
    .FETCH_OP (FETCH_OP),
    .ADD_OP   (ADD_OP)
  ) u_decode (
    .state  (state_d),
    .simm   (IR[13]),
    .ctrl_c (ctrl_c)
  );

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state_q <= S_IDLE;
      ctrl_q  <= ctrl_quiet();
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_c;
    end
  end

  assign MFA     = ctrl_q.mfa;
  assign MOP_SEL = ctrl_q.mop_sel;
  assign AOP_SEL = ctrl_q.aop_sel;
  assign OP1     = ctrl_q.op1;
  assign MAR_SEL = ctrl_q.mar_sel;
  assign MDR_SEL = ctrl_q.mdr_sel;
  assign ALU_SEL = ctrl_q.alu_sel;
  assign RA_SEL  = ctrl_q.ra_sel;
  assign RC_SEL  = ctrl_q.rc_sel;
  assign CIN_SEL = ctrl_q.cin_sel;
  assign nPC_SEL = ctrl_q.npc_sel;
  assign MARE    = ctrl_q.mare;
  assign MDRE    = ctrl_q.mdre;
  assign IRE     = ctrl_q.ire;
  assign RFE     = ctrl_q.rfe;
  assign PCE     = ctrl_q.pce;
  assign nPCE    = ctrl_q.npce;
  assign ExecReq = ctrl_q.exec_req;
  assign Busy    = ctrl_q.busy;

endmodule

// File: tb/tb_mem_cycle_sequencer.sv
// Randomized bench: a per-instruction cycle timeline built from the instruction's rules is compared against the DUT.
module tb_mem_cycle_sequencer;

  localparam logic [5:0] FETCH_OP = 6'h08;
  localparam logic [5:0] ADD_OP   = 6'h00;

  logic        Clk = 1'b0;
  logic        Clr, Start, MFC, ExecAck;
  logic [31:0] IR;
  logic        MFA, MOP_SEL, AOP_SEL;
  logic [5:0]  OP1;
  logic [1:0]  MAR_SEL, MDR_SEL, ALU_SEL, RC_SEL, CIN_SEL, nPC_SEL;
  logic        RA_SEL, MARE, MDRE, IRE, RFE, PCE, nPCE, ExecReq, Busy, MemErr;

  always #5 Clk = ~Clk;

`ifdef MEM_TIMEOUT_EN
  mem_cycle_sequencer #(.TIMEOUT_CYCLES(8)) dut (
`else
  mem_cycle_sequencer dut (
`endif
    .Clk(Clk), .Clr(Clr), .Start(Start), .IR(IR), .MFC(MFC), .ExecAck(ExecAck),
    .MFA(MFA), .MOP_SEL(MOP_SEL), .AOP_SEL(AOP_SEL), .OP1(OP1),
    .MAR_SEL(MAR_SEL), .MDR_SEL(MDR_SEL), .ALU_SEL(ALU_SEL), .RA_SEL(RA_SEL),
    .RC_SEL(RC_SEL), .CIN_SEL(CIN_SEL), .nPC_SEL(nPC_SEL),
    .MARE(MARE), .MDRE(MDRE), .IRE(IRE), .RFE(RFE), .PCE(PCE), .nPCE(nPCE),
    .ExecReq(ExecReq), .Busy(Busy), .MemErr(MemErr)
  );

  typedef struct packed {
    logic       mfa, mop_sel, aop_sel;
    logic [5:0] op1;
    logic [1:0] mar_sel, mdr_sel, alu_sel;
    logic       ra_sel;
    logic [1:0] rc_sel, cin_sel, npc_sel;
    logic       mare, mdre, ire, rfe, pce, npce, exec_req, busy, mem_err;
  } snap_t;

  snap_t       exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic snap_t observe();
    snap_t s;
    s = '{MFA, MOP_SEL, AOP_SEL, OP1, MAR_SEL, MDR_SEL, ALU_SEL, RA_SEL,
          RC_SEL, CIN_SEL, nPC_SEL, MARE, MDRE, IRE, RFE, PCE, nPCE, ExecReq, Busy, MemErr};
    return s;
  endfunction

  function automatic snap_t quiet(input logic busy);
    snap_t s;
    s = '0;
    s.mare = 1'b1; s.mdre = 1'b1; s.ire = 1'b1;
    s.rfe  = 1'b1; s.pce  = 1'b1; s.npce = 1'b1;
    s.busy = busy;
    return s;
  endfunction

  // Expected cycle-by-cycle outputs for one instruction, from F_ADDR through PC_UPD
  function automatic void model_instr(input logic [31:0] ir, input int lf, input int ld, input int le);
    snap_t s;
    exp_q.delete();
    s = quiet(1); s.mar_sel = 2'd1; s.mare = 1'b0; exp_q.push_back(s);
    repeat (lf) begin
      s = quiet(1); s.mfa = 1'b1; s.mop_sel = 1'b1; s.op1 = FETCH_OP; exp_q.push_back(s);
    end
    s = quiet(1); s.mdre = 1'b0; s.ire = 1'b0; exp_q.push_back(s);
    exp_q.push_back(quiet(1));
    if (ir[31:30] == 2'b11) begin
      if (ir[21]) begin
        s = quiet(1); s.ra_sel = 1'b1; s.mdr_sel = 2'd1; s.mdre = 1'b0; exp_q.push_back(s);
      end
      s = quiet(1); s.aop_sel = 1'b1; s.op1 = ADD_OP; s.alu_sel = ir[13] ? 2'd1 : 2'd0;
      s.mare = 1'b0; exp_q.push_back(s);
      repeat (ld) begin
        s = quiet(1); s.mfa = 1'b1; exp_q.push_back(s);
      end
      if (!ir[21]) begin
        s = quiet(1); s.mdre = 1'b0; exp_q.push_back(s);
        s = quiet(1); s.cin_sel = 2'd3; s.rfe = 1'b0; exp_q.push_back(s);
      end
    end else begin
      repeat (le) begin
        s = quiet(1); s.exec_req = 1'b1; exp_q.push_back(s);
      end
    end
    s = quiet(1); s.pce = 1'b0; s.npce = 1'b0; exp_q.push_back(s);
  endfunction

  // Entered just before the posedge that moves into F_ADDR
  task automatic run_instr(input logic [31:0] ir, input int lf, input int ld, input int le,
                           input logic chain, input int idx);
    int mfa_run = 0;
    int ex_run  = 0;
    model_instr(ir, lf, ld, le);
    IR = $urandom;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge Clk);
      check_eq($sformatf("i%0d_c%0d", idx, i), 32'(observe()), 32'(exp_q[i]));
      if (MFA) begin
        mfa_run++;
        MFC = (mfa_run == (MOP_SEL ? lf : ld));
      end else begin
        mfa_run = 0;
        MFC = 1'($urandom);
      end
      if (ExecReq) begin
        ex_run++;
        ExecAck = (ex_run == le);
      end else begin
        ex_run = 0;
        ExecAck = 1'($urandom);
      end
      if (!IRE) IR = ir;
      Start = (i == exp_q.size() - 1) ? chain : 1'($urandom);
    end
  endtask

  task automatic idle_phase(input int n, input int idx);
    for (int k = 0; k < n; k++) begin
      @(negedge Clk);
      check_eq($sformatf("idle%0d_%0d", idx, k), 32'(observe()), 32'(quiet(0)));
      MFC     = 1'($urandom);
      ExecAck = 1'($urandom);
      IR      = $urandom;
      Start   = (k == n - 1);
    end
  endtask

  initial begin
    logic [31:0] ir;
    logic        chain;
    logic        found;
    int          hi;

    Clr = 1'b0; Start = 1'b0; MFC = 1'b0; ExecAck = 1'b0; IR = '0;
    #12;
    check_eq("reset", 32'(observe()), 32'(quiet(0)));
    @(negedge Clk);
    Clr = 1'b1;
    idle_phase(2, 0);

    // Directed: ld [r0+4],r1 ; st r1,[r0+8] ; add
    run_instr(32'hC2006004, 3, 2, 1, 1'b0, 0);
    idle_phase(1, 1);
    run_instr(32'hC2202008, 2, 3, 1, 1'b0, 1);
    idle_phase(1, 2);
    run_instr(32'h82004002, 1, 1, 5, 1'b0, 2);
    idle_phase(2, 3);

    for (int t = 3; t < 40; t++) begin
      ir = $urandom;
      case ($urandom_range(0, 2))
        0: begin ir[31:30] = 2'b11; ir[21] = 1'b0; end
        1: begin ir[31:30] = 2'b11; ir[21] = 1'b1; end
        default: ir[31:30] = 2'($urandom_range(0, 2));
      endcase
      chain = (t == 39) ? 1'b0 : 1'($urandom);
      run_instr(ir, $urandom_range(1, 5), $urandom_range(1, 5), $urandom_range(1, 6), chain, t);
      if (!chain) idle_phase($urandom_range(1, 3), t + 100);
    end

    // Async reset while a load waits in D_MEM, then stale MFC must be ignored
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge Clk);
      if (MFA && !MOP_SEL) found = 1'b1;
      else begin
        MFC = MFA && MOP_SEL;
        ExecAck = 1'b0;
        if (!IRE) IR = 32'hC2006004;
      end
    end
    check_eq("reach_dmem", 32'(found), 32'd1);
    Start = 1'b0;
    #2 Clr = 1'b0;
    #1 check_eq("rst_async", 32'(observe()), 32'(quiet(0)));
    MFC = 1'b1;
    @(negedge Clk);
    Clr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      check_eq($sformatf("stale_mfc_%0d", k), 32'(observe()), 32'(quiet(0)));
    end
    MFC = 1'b0;

`ifdef MEM_TIMEOUT_EN
    Start = 1'b1;
    hi = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      if (MFA) hi++;
    end
    check_eq("timeout_mfa_cycles", 32'(hi), 32'd8);
    check_eq("timeout_err", 32'({MemErr, Busy, MFA, MARE, PCE}), 32'(5'b11011));
    Clr = 1'b0;
    #1 check_eq("err_clr", 32'(observe()), 32'(quiet(0)));
    Start = 1'b0;
    @(negedge Clk);
    Clr = 1'b1;
`else
    hi = 0;
    Start = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge Clk);
      if (MFA) hi++;
      Start = 1'b0;
    end
    check_eq("no_timeout_wait", 32'({hi, MemErr}), 32'({32'd29, 1'b0}));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
